des_key_sched: RTL and testbench

//  Sequential DES key schedule generator: accepts one 64-bit key and streams its
//  NUM_ROUNDS 48-bit round subkeys, one per handshake. Applies PC-1, the per-round
//  C/D rotations and PC-2. Encrypt order is K1..KN; decrypt order is KN..K1.

---
 rtl/des_key_sched.sv | 218 +++++++++++++++++++++
 tb/tb_des_key_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// des_key_sched: sequential DES key schedule generator.
// Takes one 64-bit key (FIPS bit 1 = key_in[63]) and streams NUM_ROUNDS 48-bit
// round subkeys (FIPS subkey bit 1 = sk_out[47]), one per valid/ready handshake.
// Encrypt order K1..KN, decrypt order KN..K1.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_valid/key_ready key handshake; key_in and decrypt sampled with it
//   abort               drop the current key, return to IDLE
//   sk_valid/sk_ready   subkey handshake
//   sk_out, sk_round    subkey and its round index minus 1
//   sk_last             final subkey of the current key
module des_key_sched #(
  parameter int unsigned NUM_ROUNDS  = 16,
  parameter logic [15:0] SHIFT_SCHED = 16'h7EFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        abort,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] sk_out,
  output logic [3:0]  sk_round,
  output logic        sk_last
);

  localparam int unsigned CD_W  = 56;
  localparam int unsigned SK_W  = 48;
  localparam int unsigned CNT_W = 5;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Total left rotation after NUM_ROUNDS rounds, mod 28.
  function automatic int unsigned total_shift();
    int unsigned sum;
    sum = 0;
    for (int k = 0; k < int'(NUM_ROUNDS); k++) begin
      sum = sum + (SHIFT_SCHED[4'(k)] ? 2 : 1);
    end
    return sum % 28;
  endfunction

  localparam int unsigned PRE_ROT   = (NUM_ROUNDS < 16) ? total_shift() : 0;
  localparam logic [4:0]  PRE_ROT_W = 5'(PRE_ROT);
  localparam logic [4:0]  N_W       = 5'(NUM_ROUNDS);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic [CD_W-1:0] pc1(input logic [63:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

  function automatic logic [CD_W-1:0] cd_rotl(input logic [CD_W-1:0] cd, input logic [4:0] n);
    return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

  function automatic logic [CD_W-1:0] cd_rotr(input logic [CD_W-1:0] cd, input logic [4:0] n);
    return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
  endfunction

  // Rotation amount of round r (1-based).
  function automatic logic [4:0] shift_of(input logic [CNT_W-1:0] r);
    return SHIFT_SCHED[4'(r - 5'd1)] ? 5'd2 : 5'd1;
  endfunction

  state_e            state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d, cd_tmp;
  logic [CNT_W-1:0]  rnd_q, rnd_d, rnd_n;
  logic              dec_q, dec_d;
  logic              key_ready_q, key_ready_d;
  logic              sk_valid_q, sk_valid_d;
  logic [SK_W-1:0]   sk_out_q, sk_out_d;
  logic [3:0]        sk_round_q, sk_round_d;
  logic              sk_last_q, sk_last_d;
  logic              accept, hs;

  assign accept = (state_q == IDLE) && key_valid && !abort;
  assign hs     = (state_q == RUN) && sk_valid_q && sk_ready && !abort;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over every handshake.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (key_valid) state_d = RUN;
        RUN:     if (hs && sk_last_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values.
  always_comb begin
    key_ready_d = (state_d == IDLE);
    cd_d        = cd_q;
    cd_tmp      = cd_q;
    rnd_d       = rnd_q;
    rnd_n       = rnd_q + 5'd1;
    dec_d       = dec_q;
    sk_valid_d  = sk_valid_q;
    sk_out_d    = sk_out_q;
    sk_round_d  = sk_round_q;
    sk_last_d   = sk_last_q;
    if (abort) begin
      sk_valid_d = 1'b0;
      sk_last_d  = 1'b0;
    end else if (accept) begin
      dec_d      = decrypt;
      rnd_d      = 5'd1;
      sk_valid_d = 1'b1;
      sk_last_d  = (N_W == 5'd1);
      if (decrypt) begin
        // Start from CD after N encrypt rotations, then step backwards.
        cd_tmp     = cd_rotl(pc1(key_in), PRE_ROT_W);
        sk_out_d   = pc2(cd_tmp);
        cd_d       = cd_rotr(cd_tmp, shift_of(N_W));
        sk_round_d = 4'(N_W - 5'd1);
      end else begin
        cd_tmp     = cd_rotl(pc1(key_in), shift_of(5'd1));
        sk_out_d   = pc2(cd_tmp);
        cd_d       = cd_tmp;
        sk_round_d = 4'd0;
      end
    end else if (hs) begin
      if (sk_last_q) begin
        sk_valid_d = 1'b0;
        sk_last_d  = 1'b0;
      end else begin
        rnd_d     = rnd_n;
        sk_last_d = (rnd_n == N_W);
        if (dec_q) begin
          // cd_q already holds CD for this round; pre-step for the next one.
          sk_out_d   = pc2(cd_q);
          sk_round_d = 4'(N_W - rnd_n);
          cd_d       = cd_rotr(cd_q, shift_of(N_W - rnd_q));
        end else begin
          cd_tmp     = cd_rotl(cd_q, shift_of(rnd_n));
          sk_out_d   = pc2(cd_tmp);
          sk_round_d = 4'(rnd_n - 5'd1);
          cd_d       = cd_tmp;
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q        <= '0;
      rnd_q       <= '0;
      dec_q       <= 1'b0;
      key_ready_q <= 1'b1;
      sk_valid_q  <= 1'b0;
      sk_out_q    <= '0;
      sk_round_q  <= '0;
      sk_last_q   <= 1'b0;
    end else begin
      cd_q        <= cd_d;
      rnd_q       <= rnd_d;
      dec_q       <= dec_d;
      key_ready_q <= key_ready_d;
      sk_valid_q  <= sk_valid_d;
      sk_out_q    <= sk_out_d;
      sk_round_q  <= sk_round_d;
      sk_last_q   <= sk_last_d;
    end
  end

  assign key_ready = key_ready_q;
  assign sk_valid  = sk_valid_q;
  assign sk_out    = sk_out_q;
  assign sk_round  = sk_round_q;
  assign sk_last   = sk_last_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: a 16-round and a 4-round instance.
module tb_des_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        key_valid = 1'b0, decrypt = 1'b0, abort = 1'b0, sk_ready = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_ready, sk_valid, sk_last;
  logic [47:0] sk_out;
  logic [3:0]  sk_round;

  logic        key_valid4 = 1'b0, decrypt4 = 1'b0, abort4 = 1'b0, sk_ready4 = 1'b1;
  logic [63:0] key_in4 = '0;
  logic        key_ready4, sk_valid4, sk_last4;
  logic [47:0] sk_out4;
  logic [3:0]  sk_round4;

  des_key_sched #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .decrypt(decrypt), .abort(abort), .sk_valid(sk_valid),
    .sk_ready(sk_ready), .sk_out(sk_out), .sk_round(sk_round), .sk_last(sk_last));

  des_key_sched #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst), .key_valid(key_valid4), .key_ready(key_ready4),
    .key_in(key_in4), .decrypt(decrypt4), .abort(abort4), .sk_valid(sk_valid4),
    .sk_ready(sk_ready4), .sk_out(sk_out4), .sk_round(sk_round4), .sk_last(sk_last4));

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] JUNK = 64'hFEDCBA9876543210;

  // Published subkeys K1..K16 of KEY.
  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push_seq(input int n, input bit dec, input int count, input bit four);
    for (int j = 0; j < count; j++) begin
      int   idx;
      exp_t e;
      idx    = dec ? n - 1 - j : j;
      e.sk   = ks[idx];
      e.rnd  = 4'(idx);
      e.last = (j == n - 1);
      if (four) q4.push_back(e);
      else      q16.push_back(e);
    end
  endtask

  // Monitor for the 16-round instance: hold check while stalled, pop on handshake.
  logic        stall16 = 1'b0;
  logic [52:0] held16 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (stall16 && sk_valid)
      chk("stall_hold16", 64'({sk_out, sk_round, sk_last}), 64'(held16));
    stall16 = sk_valid && !sk_ready && !abort && !rst;
    held16  = {sk_out, sk_round, sk_last};
    if (sk_valid && sk_ready && !abort && !rst) begin
      if (q16.size() == 0) chk("unexpected_subkey16", 64'(q16.size()), 64'd1);
      else begin
        e = q16.pop_front();
        chk("sk_out16", 64'(sk_out), 64'(e.sk));
        chk("sk_round16", 64'(sk_round), 64'(e.rnd));
        chk("sk_last16", 64'(sk_last), 64'(e.last));
      end
    end
  end

  // Monitor for the 4-round instance.
  always @(negedge clk) begin
    exp_t e;
    if (sk_valid4 && sk_ready4 && !abort4 && !rst) begin
      if (q4.size() == 0) chk("unexpected_subkey4", 64'(q4.size()), 64'd1);
      else begin
        e = q4.pop_front();
        chk("sk_out4", 64'(sk_out4), 64'(e.sk));
        chk("sk_round4", 64'(sk_round4), 64'(e.rnd));
        chk("sk_last4", 64'(sk_last4), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [63:0] k, input bit dec);
    int n = 0;
    while (!key_ready && n < 50) begin tick(); n++; end
    chk("key_ready_before_send", 64'(key_ready), 64'd1);
    key_in = k; decrypt = dec; key_valid = 1'b1;
    tick();
    key_valid = 1'b0; decrypt = 1'b0;
  endtask

  task automatic send_key4(input logic [63:0] k, input bit dec);
    int n = 0;
    while (!key_ready4 && n < 50) begin tick(); n++; end
    chk("key_ready4_before_send", 64'(key_ready4), 64'd1);
    key_in4 = k; decrypt4 = dec; key_valid4 = 1'b1;
    tick();
    key_valid4 = 1'b0; decrypt4 = 1'b0;
  endtask

  // Cycles from the acceptance edge until key_ready is seen again.
  task automatic wait_idle(input bit four, output int cyc);
    cyc = 1;
    while (!(four ? key_ready4 : key_ready) && cyc < 400) begin tick(); cyc++; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    chk({tag, "_sk_valid"},  64'(sk_valid),  64'd0);
    chk({tag, "_sk_out"},    64'(sk_out),    64'd0);
    chk({tag, "_sk_round"},  64'(sk_round),  64'd0);
    chk({tag, "_sk_last"},   64'(sk_last),   64'd0);
  endtask

  initial begin
    int cyc;
    tick(); tick();
    chk_reset_outputs("reset");
    chk("reset_key_ready4", 64'(key_ready4), 64'd1);
    chk("reset_sk_valid4", 64'(sk_valid4), 64'd0);
    rst = 1'b0;
    tick();

    // Encrypt, no backpressure.
    push_seq(16, 1'b0, 16, 1'b0);
    send_key(KEY, 1'b0);
    chk("first_valid_after_accept", 64'(sk_valid), 64'd1);
    wait_idle(1'b0, cyc);
    chk("enc_latency", 64'(cyc), 64'd17);

    // Decrypt, no backpressure.
    push_seq(16, 1'b1, 16, 1'b0);
    send_key(KEY, 1'b1);
    wait_idle(1'b0, cyc);
    chk("dec_latency", 64'(cyc), 64'd17);

    // Random stalls with a foreign key offered throughout the run.
    push_seq(16, 1'b0, 16, 1'b0);
    send_key(KEY, 1'b0);
    key_in = JUNK; key_valid = 1'b1;
    cyc = 0;
    while (!key_ready && cyc < 400) begin
      sk_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    key_valid = 1'b0; sk_ready = 1'b1;
    chk("stall_run_done", 64'(key_ready), 64'd1);

    // Abort while K6 is presented, key offered in the same cycle.
    push_seq(16, 1'b0, 5, 1'b0);
    send_key(KEY, 1'b0);
    repeat (5) tick();
    chk("k6_presented", 64'(sk_round), 64'd5);
    abort = 1'b1; key_valid = 1'b1; key_in = JUNK;
    tick();
    abort = 1'b0; key_valid = 1'b0;
    chk("abort_sk_valid", 64'(sk_valid), 64'd0);
    chk("abort_key_ready", 64'(key_ready), 64'd1);
    chk("abort_sk_last", 64'(sk_last), 64'd0);
    tick();
    chk("abort_key_not_taken", 64'(key_ready), 64'd1);
    chk("abort_no_valid", 64'(sk_valid), 64'd0);
    chk("abort_queue_empty", 64'(q16.size()), 64'd0);
    push_seq(16, 1'b0, 16, 1'b0);
    send_key(KEY, 1'b0);
    wait_idle(1'b0, cyc);
    chk("post_abort_latency", 64'(cyc), 64'd17);

    // Reset mid-run while stalled; key_valid held during RUN.
    push_seq(16, 1'b0, 3, 1'b0);
    send_key(KEY, 1'b0);
    key_in = JUNK; decrypt = 1'b1; key_valid = 1'b1;
    repeat (3) tick();
    sk_ready = 1'b0;
    tick(); tick();
    chk("k4_stalled", 64'(sk_round), 64'd3);
    key_valid = 1'b0; decrypt = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrun_reset");
    rst = 1'b0; sk_ready = 1'b1;
    tick();
    chk("reset_queue_empty", 64'(q16.size()), 64'd0);
    push_seq(16, 1'b1, 16, 1'b0);
    send_key(KEY, 1'b1);
    wait_idle(1'b0, cyc);
    chk("post_reset_dec_latency", 64'(cyc), 64'd17);

    // Reduced-round instance: encrypt then decrypt.
    push_seq(4, 1'b0, 4, 1'b1);
    send_key4(KEY, 1'b0);
    wait_idle(1'b1, cyc);
    chk("r4_enc_latency", 64'(cyc), 64'd5);
    push_seq(4, 1'b1, 4, 1'b1);
    send_key4(KEY, 1'b1);
    wait_idle(1'b1, cyc);
    chk("r4_dec_latency", 64'(cyc), 64'd5);

    tick(); tick();
    chk("q16_drained", 64'(q16.size()), 64'd0);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
